mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port synchronous RAM between the core's instruction-fetch port and its load/store port. Grants one request at a time and sequences the RAM access: issue, then response. Handles byte enables, load sign/zero extension and the misaligned/out-of-range fault check. Sits between the twitchcore pipeline and the unified program/data RAM.

Parameters:
ADDR_W, 12, RAM word-address width (RAM depth = 2**ADDR_W words of 32 bits)
BASE, 32'h80000000, byte address that maps to RAM word 0
MAX_WAIT, 4, consecutive lost arbitrations after which fetch takes priority over data

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high, if_addr stable, until if_ack
if_addr  in  32  fetch byte address
if_ack  out  1  one-cycle pulse: fetch complete
if_rdata  out  32  fetched word, valid with if_ack
if_fault  out  1  valid with if_ack: misaligned or out of range
d_req  in  1  data request; held high, inputs stable, until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_funct3  in  3  RISC-V width code: LB/LH/LW/LBU/LHU, or SB/SH/SW
d_wdata  in  32  store data, right-aligned
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  32  extended load result, valid with d_ack; 0 for stores and faults
d_fault  out  1  valid with d_ack
ram_en  out  1  RAM access enable
ram_we  out  4  RAM byte write enables
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset (async, resetn=0):
  - State = IDLE; wait_cnt = 0.
  - All outputs are 0: acks, faults, rdata, ram_en, ram_we, ram_addr, ram_wdata.
  - An in-flight access is dropped with no ack. The requester reissues it after reset.
- FSM states are IDLE, ISSUE and RESP. Every access takes exactly 3 cycles, IDLE through RESP.
- IDLE:
  - With no request pending, stay in IDLE.
  - Otherwise pick a winner and latch its address, funct3, wdata and we into internal registers, then go to ISSUE.
- Arbitration (IDLE only):
  - Only one request pending: that request wins.
  - Both pending: data wins, unless wait_cnt >= MAX_WAIT, in which case fetch wins.
  - wait_cnt increments when fetch loses to data, saturating at MAX_WAIT.
  - wait_cnt clears when fetch is granted.
- Fault check (combinational on latched values, evaluated in ISSUE):
  - Misaligned access: halfword (LH/LHU/SH) with addr[0]=1, or word (LW/SW/fetch) with addr[1:0]!=0.
  - Invalid funct3: 3'b011, or 3'b110/3'b111 when d_we=1.
  - Out of range: (addr - BASE) >= 4*2**ADDR_W, computed as 32-bit unsigned, so addresses below BASE wrap and fault.
- ISSUE:
  - No fault: ram_en=1 and ram_addr=(addr-BASE)[ADDR_W+1:2].
  - Load or fetch: ram_we=0.
  - Store byte enables: SB gives 4'b0001<<addr[1:0]; SH gives 4'b0011<<addr[1:0]; SW gives 4'b1111.
  - Store data: ram_wdata = wdata replicated (byte x4, half x2, word x1).
  - Fault: ram_en=0 and ram_we=0, so no RAM access occurs.
  - Always go to RESP.
- RESP:
  - ram_en and ram_we return to 0.
  - The winner's ack is high for exactly this cycle, with fault and rdata valid.
  - Fetch rdata = ram_rdata.
  - Load rdata: select the byte or half at addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - Store or fault: rdata = 0.
  - Next state is IDLE.
- Outside RESP, ack, fault and rdata are 0.
- The requester deasserts req on the edge that ends RESP. A req still high in IDLE is treated as a new request.
- Simultaneous arrival of both requests in IDLE is resolved by the priority rule above. The loser stays pending and is served in the next IDLE cycle.
- Back-to-back accesses never overlap; max throughput is 1 access / 3 cycles.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds three outputs, each 32-bit, each reset to 0, each wrapping at 2**32:
  - stat_if_grants: counts fetch grants.
  - stat_d_grants: counts data grants.
  - stat_conflicts: counts IDLE cycles with both requests pending.
- Undefined: these ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Fetch only, if_addr=0x80000008, RAM word 2=0x00500093:
  - ram_en high 1 cycle with ram_addr=2.
  - if_ack 2 cycles after the IDLE cycle in which if_req was sampled, with if_rdata=0x00500093 and if_fault=0.
- Loads, RAM word 1=0x80FF7F01:
  - LB at 0x80000007 gives d_rdata=0xFFFFFF80.
  - LBU at 0x80000007 gives 0x00000080.
  - LH at 0x80000006 gives 0xFFFF80FF.
  - LW at 0x80000004 gives 0x80FF7F01.
- SB 0xAB at 0x80000005:
  - ram_we=4'b0010 and ram_wdata=0xABABABAB.
  - A following LW returns the byte merged at bits 15:8.
- Faults, each acks with d_fault=1, d_rdata=0 and ram_en never asserted:
  - LW at 0x80000002.
  - SH at 0x80000001.
  - LW at 0x7FFFFFFC.
  - LW at 0x80004000 with ADDR_W=12.
- Contention: d_req and if_req held high continuously:
  - Grant order is D,D,D,D,IF, repeating with MAX_WAIT=4.
  - wait_cnt is 0 after each IF grant.
- Assert resetn=0 during ISSUE of a store:
  - No ack.
  - All outputs 0 immediately.
  - After release, a reissued LW returns the pre-store RAM value.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction
// fetch port (if_*) and the load/store port (d_*). One access at a time, each
// taking exactly three cycles: IDLE (arbitrate + latch), ISSUE (drive RAM),
// RESP (ack with fault/rdata). Handles byte enables, store data replication,
// load sign/zero extension, and misaligned / invalid / out-of-range faults.
//
// Ports:
//   clk, resetn                    clock, async active-low reset
//   if_req/if_addr                 fetch request (held until if_ack)
//   if_ack/if_rdata/if_fault       fetch completion, valid for one cycle
//   d_req/d_we/d_addr/d_funct3/d_wdata   load/store request (held until d_ack)
//   d_ack/d_rdata/d_fault          data completion, valid for one cycle
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   RAM port (read data 1 cycle later)
//
// Optional build macro MEM_ARB_STATS_EN adds stat_if_grants, stat_d_grants and
// stat_conflicts (32-bit wrapping counters).
module mem_arbiter #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] BASE     = 32'h80000000,
  parameter int          MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_fault,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [2:0]        d_funct3,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_fault,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts
`endif
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic        is_fetch;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  state_t        state, state_nxt;
  acc_t          cur;
  logic [WW-1:0] wait_cnt;
  logic          grant_if, grant_d;

  // Arbitration, only meaningful in IDLE.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (if_req && d_req) begin
      if (wait_cnt >= WAIT_MAX) grant_if = 1'b1;
      else                      grant_d  = 1'b1;
    end else if (if_req) begin
      grant_if = 1'b1;
    end else if (d_req) begin
      grant_d = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || d_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and starvation counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur      <= '0;
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_if) begin
        cur      <= '{is_fetch: 1'b1, we: 1'b0, funct3: 3'b010, addr: if_addr, wdata: 32'h0};
        wait_cnt <= '0;
      end else if (grant_d) begin
        cur <= '{is_fetch: 1'b0, we: d_we, funct3: d_funct3, addr: d_addr, wdata: d_wdata};
        // Data only beats a pending fetch while wait_cnt < MAX_WAIT, so this
        // increment saturates on its own.
        if (if_req) wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Fault check on the latched access
  logic [31:0] off;
  logic        is_byte, is_half, bad_f3, misalign, oor, fault;
  logic        unused_off;

  always_comb begin
    off      = cur.addr - BASE;
    is_byte  = (cur.funct3[1:0] == 2'b00);
    is_half  = (cur.funct3[1:0] == 2'b01);
    bad_f3   = !cur.is_fetch &&
               ((cur.funct3 == 3'b011) || (cur.we && cur.funct3[2:1] == 2'b11));
    misalign = is_half ? cur.addr[0] : (!is_byte && cur.addr[1:0] != 2'b00);
    // Unsigned wrap makes addresses below BASE land far out of range.
    oor      = |off[31:ADDR_W+2];
    fault    = bad_f3 | misalign | oor;
  end

  assign unused_off = ^off[1:0];

  // Store lanes and load extension
  logic [3:0]  we_mask;
  logic [31:0] wdata_rep, shifted, load_val;

  always_comb begin
    case (cur.funct3[1:0])
      2'b00: begin
        we_mask   = 4'b0001 << cur.addr[1:0];
        wdata_rep = {4{cur.wdata[7:0]}};
      end
      2'b01: begin
        we_mask   = 4'b0011 << cur.addr[1:0];
        wdata_rep = {2{cur.wdata[15:0]}};
      end
      default: begin
        we_mask   = 4'b1111;
        wdata_rep = cur.wdata;
      end
    endcase
    shifted = ram_rdata >> {cur.addr[1:0], 3'b000};
    case (cur.funct3[1:0])
      2'b00:   load_val = {{24{~cur.funct3[2] & shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = {{16{~cur.funct3[2] & shifted[15]}}, shifted[15:0]};
      default: load_val = ram_rdata;
    endcase
  end

  // Outputs decoded from state so reset clears them immediately.
  always_comb begin
    if_ack    = 1'b0;
    if_rdata  = '0;
    if_fault  = 1'b0;
    d_ack     = 1'b0;
    d_rdata   = '0;
    d_fault   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      ISSUE: if (!fault) begin
        ram_en   = 1'b1;
        ram_addr = off[ADDR_W+1:2];
        if (cur.we) begin
          ram_we    = we_mask;
          ram_wdata = wdata_rep;
        end
      end
      RESP: begin
        if (cur.is_fetch) begin
          if_ack   = 1'b1;
          if_fault = fault;
          if_rdata = fault ? 32'h0 : ram_rdata;
        end else begin
          d_ack   = 1'b1;
          d_fault = fault;
          d_rdata = (fault || cur.we) ? 32'h0 : load_val;
        end
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_if_grants <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else if (state == IDLE) begin
      if (grant_if)         stat_if_grants <= stat_if_grants + 32'd1;
      if (grant_d)          stat_d_grants  <= stat_d_grants + 32'd1;
      if (if_req && d_req)  stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter. A byte-addressed reference
// memory computes each access result when the request is issued; a monitor
// pops expectations on every ack.
module tb_mem_arbiter;
  localparam int          ADDR_W   = 12;
  localparam logic [31:0] BASE     = 32'h80000000;
  localparam int          MAX_WAIT = 4;
  localparam int          DEPTH    = 1 << ADDR_W;

  logic              clk, resetn;
  logic              if_req, if_ack, if_fault;
  logic [31:0]       if_addr, if_rdata;
  logic              d_req, d_we, d_ack, d_fault;
  logic [31:0]       d_addr, d_wdata, d_rdata;
  logic [2:0]        d_funct3;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .BASE(BASE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_fault(if_fault),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_funct3(d_funct3), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_fault(d_fault),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_q;
  int                en_cnt = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [3:0]        last_we = '0;
  logic [31:0]       last_wdata = '0;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      rd_q      <= mem[ram_addr];
      en_cnt    <= en_cnt + 1;
      last_addr <= ram_addr;
      if (|ram_we) begin
        last_we    <= ram_we;
        last_wdata <= ram_wdata;
      end
    end
  end
  assign ram_rdata = rd_q;

  // Reference model
  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          fault;
  } exp_t;

  logic [7:0] gold [4*DEPTH];
  exp_t       exp_q[$];
  int         mw = 0;
  int         checks = 0, errors = 0;
  logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd0, 3'd3};
  logic [2:0] st_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) gold[4*w+i] = v[8*i +: 8];
  endtask

  function automatic exp_t model_op(input bit is_d, input bit we, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          size;
    bit          sgn, invalid;
    logic [31:0] off, v;
    e.is_d = is_d; e.rdata = 32'h0; e.fault = 1'b0;
    off = addr - BASE;
    size = 4; sgn = 1'b0; invalid = 1'b0;
    if (is_d) begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd4: size = 1;
        3'd5: size = 2;
        3'd3: invalid = 1'b1;
        3'd6, 3'd7: invalid = we;
        default: size = 4;
      endcase
    end
    e.fault = invalid || (off >= 32'(4*DEPTH)) || ((off % 32'(size)) != 0);
    if (e.fault) return e;
    if (is_d && we) begin
      for (int i = 0; i < size; i++) gold[off+32'(i)] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(gold[off+32'(i)]) << (8*i));
      if (sgn && v[8*size-1]) v = v | (32'hFFFFFFFF << (8*size));
      e.rdata = v;
    end
    return e;
  endfunction

  function automatic bit outs_zero();
    return !if_ack && if_rdata == 0 && !if_fault && !d_ack && d_rdata == 0 && !d_fault &&
           !ram_en && ram_we == 0 && ram_addr == 0 && ram_wdata == 0;
  endfunction

  // Monitor
  initial begin
    exp_t        e;
    bit          gd, gf;
    logic [31:0] gr;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (if_ack || d_ack) begin
          checks++;
          if (if_ack && d_ack) begin
            errors++; $display("FAIL dual_ack: both acks high, required one");
          end else if (exp_q.size() == 0) begin
            errors++; $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b, required none", if_ack, d_ack);
          end else begin
            e  = exp_q.pop_front();
            gd = d_ack;
            gr = d_ack ? d_rdata : if_rdata;
            gf = d_ack ? d_fault : if_fault;
            if (gd != e.is_d || gr != e.rdata || gf != e.fault) begin
              errors++;
              $display("FAIL resp: port_d=%0b rdata=%h fault=%0b, required port_d=%0b rdata=%h fault=%0b",
                       gd, gr, gf, e.is_d, e.rdata, e.fault);
            end
          end
          if (if_ack) begin
            checks++;
            if (dut.wait_cnt != 0) begin
              errors++; $display("FAIL wait_cnt: %0d after fetch grant, required 0", dut.wait_cnt);
            end
          end
        end
        checks++;
        if ((!if_ack && (if_fault || if_rdata != 0)) || (!d_ack && (d_fault || d_rdata != 0))) begin
          errors++;
          $display("FAIL quiet: if_f=%0b if_r=%h d_f=%0b d_r=%h without ack, required 0",
                   if_fault, if_rdata, d_fault, d_rdata);
        end
      end
    end
  end

  // One slot: optional fetch, optional data, run until both acked.
  task automatic run_slot(input bit do_if, input logic [31:0] ia, input bit do_d, input bit we,
                          input logic [2:0] f3, input logic [31:0] da, input logic [31:0] wd,
                          output int lat);
    exp_t ef, ed;
    int   en0, hits;
    @(negedge clk);
    en0 = en_cnt; hits = 0;
    if_addr = ia; d_we = we; d_funct3 = f3; d_addr = da; d_wdata = wd;
    if (do_if && do_d && mw >= MAX_WAIT) begin
      ef = model_op(0, 0, 3'd2, ia, 0); mw = 0;
      ed = model_op(1, we, f3, da, wd);
      exp_q.push_back(ef); exp_q.push_back(ed);
    end else if (do_if && do_d) begin
      ed = model_op(1, we, f3, da, wd); mw = mw + 1;
      ef = model_op(0, 0, 3'd2, ia, 0); mw = 0;
      exp_q.push_back(ed); exp_q.push_back(ef);
    end else if (do_if) begin
      ef = model_op(0, 0, 3'd2, ia, 0); mw = 0;
      exp_q.push_back(ef);
    end else if (do_d) begin
      ed = model_op(1, we, f3, da, wd);
      exp_q.push_back(ed);
    end
    if (do_if && !ef.fault) hits++;
    if (do_d && !ed.fault) hits++;
    if_req = do_if; d_req = do_d;
    lat = -1;
    for (int c = 1; c <= 40 && (if_req || d_req); c++) begin
      @(negedge clk);
      if ((if_ack || d_ack) && lat < 0) lat = c;
      if (if_ack) if_req = 1'b0;
      if (d_ack)  d_req  = 1'b0;
    end
    checks++;
    if (if_req || d_req) begin
      errors++; $display("FAIL slot_timeout: reqs still pending (if=%0b d=%0b), required acked", if_req, d_req);
      if_req = 1'b0; d_req = 1'b0; exp_q.delete();
    end else if (en_cnt - en0 != hits) begin
      errors++; $display("FAIL ram_en_count: %0d cycles, required %0d", en_cnt - en0, hits);
    end
  endtask

  task automatic run_contend(input int n);
    int acks;
    acks = 0;
    @(negedge clk);
    if_addr = BASE + 32'h8; d_we = 1'b0; d_funct3 = 3'd2; d_addr = BASE + 32'h4; d_wdata = 0;
    for (int i = 0; i < n; i++) begin
      if (mw >= MAX_WAIT) begin exp_q.push_back(model_op(0, 0, 3'd2, if_addr, 0)); mw = 0; end
      else begin exp_q.push_back(model_op(1, 0, 3'd2, d_addr, 0)); mw = mw + 1; end
    end
    if_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 6*n && acks < n; c++) begin
      @(negedge clk);
      if (if_ack) acks++;
      if (d_ack)  acks++;
      if (acks >= n) begin if_req = 1'b0; d_req = 1'b0; end
    end
    checks++;
    if (acks < n) begin
      errors++; $display("FAIL contend_timeout: %0d acks, required %0d", acks, n);
      if_req = 1'b0; d_req = 1'b0; exp_q.delete();
    end
  endtask

  function automatic logic [31:0] rand_daddr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return $urandom;
    if (r == 1) return BASE - 32'($urandom_range(1, 64));
    if (r == 2) return BASE + 32'(4*DEPTH) + 32'($urandom_range(0, 64));
    return BASE + 32'($urandom_range(0, 255));
  endfunction

  initial begin
    int lat, kind, sz;
    bit we;
    logic [2:0]  f3;
    logic [31:0] ia, da, wd;

    resetn = 1'b0; if_req = 0; d_req = 0; if_addr = 0;
    d_we = 0; d_addr = 0; d_funct3 = 0; d_wdata = 0;
    for (int w = 0; w < DEPTH; w++) set_word(w, $urandom);
    set_word(1, 32'h80FF7F01);
    set_word(2, 32'h00500093);
    set_word(4, 32'h11223344);
    @(negedge clk);
    checks++;
    if (!outs_zero()) begin errors++; $display("FAIL reset_outputs: some output nonzero, required all 0"); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Fetch
    run_slot(1, BASE + 32'h8, 0, 0, 0, 0, 0, lat);
    checks++;
    if (lat != 2 || last_addr != 2) begin
      errors++; $display("FAIL fetch_timing: lat=%0d ram_addr=%0d, required lat=2 ram_addr=2", lat, last_addr);
    end
    // Loads
    run_slot(0, 0, 1, 0, 3'd0, BASE + 32'h7, 0, lat);
    run_slot(0, 0, 1, 0, 3'd4, BASE + 32'h7, 0, lat);
    run_slot(0, 0, 1, 0, 3'd1, BASE + 32'h6, 0, lat);
    run_slot(0, 0, 1, 0, 3'd2, BASE + 32'h4, 0, lat);
    // SB and readback
    run_slot(0, 0, 1, 1, 3'd0, BASE + 32'h5, 32'h000000AB, lat);
    checks++;
    if (last_we != 4'b0010 || last_wdata != 32'hABABABAB) begin
      errors++; $display("FAIL sb_lanes: we=%b wdata=%h, required 0010 ABABABAB", last_we, last_wdata);
    end
    run_slot(0, 0, 1, 0, 3'd2, BASE + 32'h4, 0, lat);
    // Faults
    run_slot(0, 0, 1, 0, 3'd2, BASE + 32'h2, 0, lat);
    run_slot(0, 0, 1, 1, 3'd1, BASE + 32'h1, 32'h1234, lat);
    run_slot(0, 0, 1, 0, 3'd2, 32'h7FFFFFFC, 0, lat);
    run_slot(0, 0, 1, 0, 3'd2, 32'h80004000, 0, lat);
    run_slot(0, 0, 1, 0, 3'd3, BASE + 32'h8, 0, lat);

    // Contention
    run_slot(1, BASE, 0, 0, 0, 0, 0, lat);
    run_contend(15);

    // Reset in ISSUE of a store
    @(negedge clk);
    d_we = 1'b1; d_funct3 = 3'd2; d_addr = BASE + 32'h10; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    for (int c = 0; c < 10 && !ram_en; c++) @(negedge clk);
    checks++;
    if (!ram_en) begin errors++; $display("FAIL rst_issue: ram_en never seen, required store issue"); end
    resetn = 1'b0;
    #1;
    checks++;
    if (!outs_zero()) begin errors++; $display("FAIL rst_async: outputs nonzero during reset, required all 0"); end
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1; mw = 0;
    run_slot(0, 0, 1, 0, 3'd2, BASE + 32'h10, 0, lat);

    // Random
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 2);
      ia = BASE + 32'(4 * $urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ia = rand_daddr();
      we = $urandom_range(0, 2) == 0;
      f3 = we ? st_f3[$urandom_range(0, 7)] : ld_f3[$urandom_range(0, 7)];
      sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      da = rand_daddr();
      if ($urandom_range(0, 3) != 0) da = da & ~32'(sz - 1);
      wd = $urandom;
      run_slot(kind != 1, ia, kind != 0, we, f3, da, wd, lat);
      if (kind != 2) begin
        checks++;
        if (lat != 2) begin errors++; $display("FAIL latency: %0d cycles, required 2", lat); end
      end
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: %0d expected acks missing, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
